therm_ramp_enc: RTL



---
 rtl/therm_ramp_enc.sv | 83 ++++++++
 1 files changed

// File: rtl/therm_ramp_enc.sv
// rtl/therm_ramp_enc.sv - slew-limited binary-to-thermometer encoder
// Steps a registered thermometer level toward a saturating adder target.
module therm_ramp_enc #(
  parameter int WIDTH    = 4,
  parameter int MAX_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_sum,
  input  logic                  in_carry,
  output logic [2**WIDTH-2:0]   therm,
  output logic [WIDTH-1:0]      level,
  output logic                  busy,
  output logic                  settled
);
  localparam int TW = 2**WIDTH - 1;
  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(MAX_STEP);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] target;
  logic [WIDTH:0]   lvl_x;
  logic [WIDTH:0]   tgt_x;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   lvl_n;
  logic [TW-1:0]    therm_n;

  // Arithmetic is one bit wider than the level so the step never wraps.
  always_comb begin
    target  = in_carry ? '1 : in_sum;
    lvl_x   = {1'b0, level};
    tgt_x   = {1'b0, tgt_q};
    diff    = (tgt_x > lvl_x) ? (tgt_x - lvl_x) : (lvl_x - tgt_x);
    step    = (diff < STEP) ? diff : STEP;
    lvl_n   = (tgt_x > lvl_x) ? (lvl_x + step) : (lvl_x - step);
    therm_n = '0;
    for (int i = 0; i < TW; i++) begin
      therm_n[i] = (lvl_n > (WIDTH+1)'(i));
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == RAMP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      tgt_q   <= '0;
      level   <= '0;
      therm   <= '0;
      settled <= 1'b0;
    end else begin
      settled <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            tgt_q <= target;
            if (target != level) begin
              state <= RAMP;
            end else begin
              settled <= 1'b1;
            end
          end
        end
        RAMP: begin
          level <= lvl_n[WIDTH-1:0];
          therm <= therm_n;
          if (lvl_n == tgt_x) begin
            state   <= IDLE;
            settled <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
